mul_delay_pipe: RTL and testbench

MUL_DELAY_PIPE -- requirements
Module: mul_delay_pipe

---
 rtl/vi_pkg.sv | 18 +
 rtl/mul_delay_pipe_if.sv | 48 ++++
 rtl/pipe_stage_reg.sv | 52 +++++
 rtl/mul_delay_pipe.sv | 104 ++++++++++
 tb/tb_mul_delay_pipe.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vi_pkg.sv
// Shared widths and the stage record for the result delay pipe.
// The record layout matches the payload order the pipe stores per stage.
package vi_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned XLEN       = 32;

  typedef struct packed {
    logic                  valid;
    logic                  wr_en;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
    logic [XLEN-1:0]       instr;
    logic [XLEN-1:0]       pc;
  } stage_t;

endpackage

// File: rtl/mul_delay_pipe_if.sv
// Bus bundle of the result delay pipe: entry input, pipe controls, final-stage
// output, bypass lookup and occupancy. The DUT takes the slave view.
interface mul_delay_pipe_if #(
  parameter int unsigned DEPTH  = 5,
  parameter int unsigned DATA_W = vi_pkg::DATA_W_DEF,
  parameter int unsigned ADDR_W = vi_pkg::ADDR_W_DEF
);
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic                    valid_i;
  logic [DATA_W-1:0]       data_i;
  logic [ADDR_W-1:0]       addr_i;
  logic                    wr_en_i;
  logic [vi_pkg::XLEN-1:0] instr_i;
  logic [vi_pkg::XLEN-1:0] pc_i;
  logic                    stall_i;
  logic                    flush_i;
  logic [ADDR_W-1:0]       rd_addr_a_i;
  logic [ADDR_W-1:0]       rd_addr_b_i;

  logic                    valid_o;
  logic [DATA_W-1:0]       data_o;
  logic [ADDR_W-1:0]       addr_o;
  logic                    wr_en_o;
  logic [vi_pkg::XLEN-1:0] instr_o;
  logic [vi_pkg::XLEN-1:0] pc_o;
  logic                    hit_a_o;
  logic                    hit_b_o;
  logic [DATA_W-1:0]       hit_data_a_o;
  logic [DATA_W-1:0]       hit_data_b_o;
  logic                    stall_req_o;
  logic [OccW-1:0]         occupancy_o;

  modport master (
    output valid_i, data_i, addr_i, wr_en_i, instr_i, pc_i, stall_i, flush_i,
           rd_addr_a_i, rd_addr_b_i,
    input  valid_o, data_o, addr_o, wr_en_o, instr_o, pc_o, hit_a_o, hit_b_o,
           hit_data_a_o, hit_data_b_o, stall_req_o, occupancy_o
  );

  modport slave (
    input  valid_i, data_i, addr_i, wr_en_i, instr_i, pc_i, stall_i, flush_i,
           rd_addr_a_i, rd_addr_b_i,
    output valid_o, data_o, addr_o, wr_en_o, instr_o, pc_o, hit_a_o, hit_b_o,
           hit_data_a_o, hit_data_b_o, stall_req_o, occupancy_o
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// One delay stage: shift in, hold on stall, kill on flush (flush beats stall).
module pipe_stage_reg #(
  parameter int unsigned PAYLOAD_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 valid_i,
  input  logic                 wr_en_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  output logic                 valid_o,
  output logic                 wr_en_o,
  output logic [PAYLOAD_W-1:0] payload_o
);

  logic                 valid_d, valid_q;
  logic                 wr_en_d, wr_en_q;
  logic [PAYLOAD_W-1:0] payload_d, payload_q;

  always_comb begin
    valid_d   = valid_q;
    wr_en_d   = wr_en_q;
    payload_d = payload_q;
    if (flush_i) begin
      valid_d   = 1'b0;
      wr_en_d   = 1'b0;
      payload_d = payload_i;
    end else if (!stall_i) begin
      valid_d   = valid_i;
      wr_en_d   = wr_en_i;
      payload_d = payload_i;
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      valid_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      wr_en_q   <= wr_en_d;
      payload_q <= payload_d;
    end
  end

  assign valid_o   = valid_q;
  assign wr_en_o   = wr_en_q;
  assign payload_o = payload_q;

endmodule

// File: rtl/mul_delay_pipe.sv
// Fixed-latency result delay pipe with a register bypass lookup over all stages.
// Stages at or beyond READY_STAGE forward data; younger matches request a stall.
module mul_delay_pipe import vi_pkg::*; #(
  parameter int unsigned DEPTH       = 5,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned READY_STAGE = DEPTH
) (
  input logic             clk_i,
  input logic             rsn_i,
  mul_delay_pipe_if.slave bus
);

  localparam int unsigned PayloadW = ADDR_W + DATA_W + 2 * XLEN;
  localparam int unsigned OccW     = $clog2(DEPTH + 1);
  localparam int unsigned Last     = DEPTH - 1;

  logic                in_valid   [DEPTH];
  logic                in_wr_en   [DEPTH];
  logic [PayloadW-1:0] in_payload [DEPTH];
  logic                st_valid   [DEPTH];
  logic                st_wr_en   [DEPTH];
  logic [PayloadW-1:0] st_payload [DEPTH];
  logic [ADDR_W-1:0]   st_addr    [DEPTH];
  logic [DATA_W-1:0]   st_data    [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      // Gate wr_en with valid so an invalid stage never carries a live write.
      assign in_valid[k]   = bus.valid_i;
      assign in_wr_en[k]   = bus.valid_i & bus.wr_en_i;
      assign in_payload[k] = {bus.addr_i, bus.data_i, bus.instr_i, bus.pc_i};
    end else begin : g_body
      assign in_valid[k]   = st_valid[k-1];
      assign in_wr_en[k]   = st_wr_en[k-1];
      assign in_payload[k] = st_payload[k-1];
    end

    pipe_stage_reg #(
      .PAYLOAD_W (PayloadW)
    ) u_stage (
      .clk_i     (clk_i),
      .rsn_i     (rsn_i),
      .stall_i   (bus.stall_i),
      .flush_i   (bus.flush_i),
      .valid_i   (in_valid[k]),
      .wr_en_i   (in_wr_en[k]),
      .payload_i (in_payload[k]),
      .valid_o   (st_valid[k]),
      .wr_en_o   (st_wr_en[k]),
      .payload_o (st_payload[k])
    );

    assign st_addr[k] = st_payload[k][PayloadW-1 -: ADDR_W];
    assign st_data[k] = st_payload[k][2*XLEN +: DATA_W];
  end

  assign bus.valid_o = st_valid[Last];
  assign bus.wr_en_o = st_valid[Last] & st_wr_en[Last];
  assign {bus.addr_o, bus.data_o, bus.instr_o, bus.pc_o} = st_payload[Last];

  logic [ADDR_W-1:0] rd_addr  [2];
  logic              hit      [2];
  logic              wait_req [2];
  logic [DATA_W-1:0] hit_data [2];

  assign rd_addr[0] = bus.rd_addr_a_i;
  assign rd_addr[1] = bus.rd_addr_b_i;

  // Walk oldest to youngest so the youngest match is the last one written.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      hit[s]      = 1'b0;
      wait_req[s] = 1'b0;
      hit_data[s] = '0;
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (st_valid[k] && st_wr_en[k] && (st_addr[k] == rd_addr[s]) &&
            (rd_addr[s] != '0)) begin
          hit[s]      = (k + 1 >= int'(READY_STAGE));
          wait_req[s] = (k + 1 < int'(READY_STAGE));
          hit_data[s] = (k + 1 >= int'(READY_STAGE)) ? st_data[k] : '0;
        end
      end
    end
  end

  assign bus.hit_a_o      = hit[0];
  assign bus.hit_b_o      = hit[1];
  assign bus.hit_data_a_o = hit_data[0];
  assign bus.hit_data_b_o = hit_data[1];
  assign bus.stall_req_o  = wait_req[0] | wait_req[1];

  logic [OccW-1:0] occ;

  always_comb begin
    occ = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      occ = occ + OccW'(st_valid[k]);
    end
  end

  assign bus.occupancy_o = occ;

endmodule

// File: tb/tb_mul_delay_pipe.sv
// Bench for mul_delay_pipe: two DUTs (READY_STAGE 5 and 4) share one stimulus
// stream and are checked every cycle against a stage-array model.
module tb_mul_delay_pipe;
  import vi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid, in_wr_en, in_stall, in_flush;
  logic [4:0]  in_addr, rd_a, rd_b;
  logic [31:0] in_data, in_instr, in_pc;
  logic [31:0] fill [5];
  int          ncmp = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  mul_delay_pipe_if #(.DEPTH(5), .DATA_W(32), .ADDR_W(5)) if5 ();
  mul_delay_pipe_if #(.DEPTH(5), .DATA_W(32), .ADDR_W(5)) if4 ();

  mul_delay_pipe #(.DEPTH(5), .DATA_W(32), .ADDR_W(5), .READY_STAGE(5)) u_dut5 (
    .clk_i (clk),
    .rsn_i (rst_n),
    .bus   (if5)
  );

  mul_delay_pipe #(.DEPTH(5), .DATA_W(32), .ADDR_W(5), .READY_STAGE(4)) u_dut4 (
    .clk_i (clk),
    .rsn_i (rst_n),
    .bus   (if4)
  );

  assign if5.valid_i = in_valid;     assign if4.valid_i = in_valid;
  assign if5.wr_en_i = in_wr_en;     assign if4.wr_en_i = in_wr_en;
  assign if5.addr_i = in_addr;       assign if4.addr_i = in_addr;
  assign if5.data_i = in_data;       assign if4.data_i = in_data;
  assign if5.instr_i = in_instr;     assign if4.instr_i = in_instr;
  assign if5.pc_i = in_pc;           assign if4.pc_i = in_pc;
  assign if5.stall_i = in_stall;     assign if4.stall_i = in_stall;
  assign if5.flush_i = in_flush;     assign if4.flush_i = in_flush;
  assign if5.rd_addr_a_i = rd_a;     assign if4.rd_addr_a_i = rd_a;
  assign if5.rd_addr_b_i = rd_b;     assign if4.rd_addr_b_i = rd_b;

  // Index 0 is the READY_STAGE=5 DUT, index 1 the READY_STAGE=4 DUT.
  logic        o_valid [2], o_wr_en [2], o_hit_a [2], o_hit_b [2], o_stall [2];
  logic [4:0]  o_addr [2];
  logic [31:0] o_data [2], o_instr [2], o_pc [2], o_hd_a [2], o_hd_b [2];
  logic [2:0]  o_occ [2];

  assign o_valid[0] = if5.valid_o;      assign o_valid[1] = if4.valid_o;
  assign o_wr_en[0] = if5.wr_en_o;      assign o_wr_en[1] = if4.wr_en_o;
  assign o_addr[0] = if5.addr_o;        assign o_addr[1] = if4.addr_o;
  assign o_data[0] = if5.data_o;        assign o_data[1] = if4.data_o;
  assign o_instr[0] = if5.instr_o;      assign o_instr[1] = if4.instr_o;
  assign o_pc[0] = if5.pc_o;            assign o_pc[1] = if4.pc_o;
  assign o_hit_a[0] = if5.hit_a_o;      assign o_hit_a[1] = if4.hit_a_o;
  assign o_hit_b[0] = if5.hit_b_o;      assign o_hit_b[1] = if4.hit_b_o;
  assign o_hd_a[0] = if5.hit_data_a_o;  assign o_hd_a[1] = if4.hit_data_a_o;
  assign o_hd_b[0] = if5.hit_data_b_o;  assign o_hd_b[1] = if4.hit_data_b_o;
  assign o_stall[0] = if5.stall_req_o;  assign o_stall[1] = if4.stall_req_o;
  assign o_occ[0] = if5.occupancy_o;    assign o_occ[1] = if4.occupancy_o;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: m[k] is the entry sitting in stage k (1 = youngest).
  stage_t m [1:5];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= 5; k++) m[k] <= '0;
    end else if (in_flush) begin
      for (int k = 1; k <= 5; k++) m[k].valid <= 1'b0;
    end else if (!in_stall) begin
      m[1] <= '{in_valid, in_wr_en, in_addr, in_data, in_instr, in_pc};
      for (int k = 5; k >= 2; k--) m[k] <= m[k-1];
    end
  end

  function automatic void exp_lookup(input int ready, input logic [4:0] ra,
                                     output logic hit, output logic [31:0] hd,
                                     output logic st);
    hit = 1'b0;
    hd  = '0;
    st  = 1'b0;
    if (ra == 5'd0) return;
    for (int k = 1; k <= 5; k++) begin
      if (m[k].valid && m[k].wr_en && m[k].addr == ra) begin
        if (k >= ready) begin
          hit = 1'b1;
          hd  = m[k].data;
        end else begin
          st = 1'b1;
        end
        return;
      end
    end
  endfunction

  logic        e_ha, e_hb, e_sa, e_sb;
  logic [31:0] e_da, e_db;
  int          e_occ, rs;

  always @(negedge clk) begin
    e_occ = 0;
    for (int k = 1; k <= 5; k++) e_occ += int'(m[k].valid);
    for (int d = 0; d < 2; d++) begin
      rs = (d == 0) ? 5 : 4;
      exp_lookup(rs, rd_a, e_ha, e_da, e_sa);
      exp_lookup(rs, rd_b, e_hb, e_db, e_sb);
      check($sformatf("r%0d_valid_o", rs), o_valid[d], m[5].valid);
      check($sformatf("r%0d_wr_en_o", rs), o_wr_en[d], m[5].valid & m[5].wr_en);
      check($sformatf("r%0d_occupancy", rs), o_occ[d], e_occ);
      check($sformatf("r%0d_hit_a", rs), o_hit_a[d], e_ha);
      check($sformatf("r%0d_hit_data_a", rs), o_hd_a[d], e_da);
      check($sformatf("r%0d_hit_b", rs), o_hit_b[d], e_hb);
      check($sformatf("r%0d_hit_data_b", rs), o_hd_b[d], e_db);
      check($sformatf("r%0d_stall_req", rs), o_stall[d], e_sa | e_sb);
      if (m[5].valid) begin
        check($sformatf("r%0d_data_o", rs), o_data[d], m[5].data);
        check($sformatf("r%0d_addr_o", rs), o_addr[d], m[5].addr);
        check($sformatf("r%0d_instr_o", rs), o_instr[d], m[5].instr);
        check($sformatf("r%0d_pc_o", rs), o_pc[d], m[5].pc);
      end
    end
  end

  initial begin
    in_valid = 0; in_wr_en = 0; in_stall = 0; in_flush = 0;
    in_addr = 0; in_data = 0; in_instr = 0; in_pc = 0; rd_a = 0; rd_b = 0;
    #2 rst_n = 1'b0;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      check("reset_valid_o", o_valid[d], 0);
      check("reset_wr_en_o", o_wr_en[d], 0);
      check("reset_data_o", o_data[d], 0);
      check("reset_occupancy", o_occ[d], 0);
      check("reset_stall_req", o_stall[d], 0);
    end
    rst_n = 1'b1;

    // Single entry travels exactly five edges.
    in_valid = 1; in_wr_en = 1; in_addr = 7; in_data = 32'hDEAD_BEEF;
    in_instr = 32'h0070_0093; in_pc = 32'h0000_0100;
    tick();
    in_valid = 0;
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("latency_occ_%0d", i), o_occ[0], 1);
      check($sformatf("latency_valid_%0d", i), o_valid[0], (i == 5));
      if (i < 5) tick();
    end
    check("latency_data", o_data[0], 32'hDEAD_BEEF);
    check("latency_addr", o_addr[0], 7);
    check("latency_wr_en", o_wr_en[0], 1);
    check("latency_pc", o_pc[0], 32'h0000_0100);
    tick();
    check("latency_drained", o_occ[0], 0);

    // Not-yet-ready match stalls, then forwards once it reaches stage 5.
    in_valid = 1; in_addr = 3; in_data = 32'h1234_5678;
    tick();
    in_valid = 0;
    tick();
    rd_a = 3;
    #1;
    check("early_hit_a", o_hit_a[0], 0);
    check("early_stall_req", o_stall[0], 1);
    repeat (3) tick();
    check("ready_hit_a", o_hit_a[0], 1);
    check("ready_hit_data_a", o_hd_a[0], 32'h1234_5678);
    check("ready_stall_req", o_stall[0], 0);
    rd_a = 0;
    tick();

    // Youngest of two matches wins.
    in_valid = 1; in_addr = 9; in_data = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    in_valid = 0;
    repeat (3) tick();
    rd_b = 9;
    #1;
    check("youngest_hit_b", o_hit_b[1], 1);
    check("youngest_hit_data_b", o_hd_b[1], 32'h22);
    check("youngest_r5_hit_b", o_hit_b[0], 0);
    check("youngest_r5_stall", o_stall[0], 1);
    tick();
    check("youngest_r5_late_hit_b", o_hit_b[0], 1);
    check("youngest_r5_late_data_b", o_hd_b[0], 32'h22);
    rd_b = 0;
    tick();

    // Full pipe holds under stall; flush wins over stall.
    for (int i = 0; i < 5; i++) begin
      fill[i] = $urandom; in_valid = 1; in_addr = 5'(10 + i); in_data = fill[i];
      tick();
    end
    in_stall = 1; in_data = $urandom;
    check("stall_occ_0", o_occ[0], 5);
    check("stall_data_0", o_data[0], fill[0]);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("stall_occ_%0d", i), o_occ[0], 5);
      check($sformatf("stall_data_%0d", i), o_data[0], fill[0]);
      check($sformatf("stall_addr_%0d", i), o_addr[0], 10);
    end
    in_flush = 1;
    tick();
    check("flush_occ", o_occ[0], 0);
    check("flush_valid_o", o_valid[0], 0);
    check("flush_wr_en_o", o_wr_en[0], 0);
    in_flush = 0; in_stall = 0; in_valid = 0;

    // Register 0 never matches.
    in_valid = 1; in_addr = 0; in_wr_en = 1; in_data = 32'h0000_A5A5;
    tick();
    in_valid = 0;
    repeat (4) tick();
    rd_a = 0;
    #1;
    check("zero_valid_o", o_valid[0], 1);
    check("zero_hit_a", o_hit_a[0], 0);
    check("zero_stall_req", o_stall[0], 0);
    tick();

    // Non-writing entry never matches.
    in_valid = 1; in_wr_en = 0; in_addr = 6;
    tick();
    in_valid = 0; in_wr_en = 1; rd_a = 6;
    #1;
    check("nowr_stall_req", o_stall[0], 0);
    check("nowr_hit_a", o_hit_a[0], 0);
    repeat (5) tick();
    rd_a = 0;

    // Asynchronous reset between edges with four entries in flight.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_addr = 5'(20 + i); in_data = $urandom;
      tick();
    end
    in_valid = 0; rd_a = 23;
    #1;
    check("prereset_occ", o_occ[0], 4);
    check("prereset_stall_req", o_stall[0], 1);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("async_reset_valid_o", o_valid[d], 0);
      check("async_reset_wr_en_o", o_wr_en[d], 0);
      check("async_reset_data_o", o_data[d], 0);
      check("async_reset_occ", o_occ[d], 0);
      check("async_reset_stall_req", o_stall[d], 0);
      check("async_reset_hit_a", o_hit_a[d], 0);
    end
    tick();
    rst_n = 1'b1; rd_a = 0;

    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(3, 0) != 0);
      in_wr_en = ($urandom_range(3, 0) != 0);
      in_addr  = 5'($urandom_range(7, 0));
      in_data  = $urandom;
      in_instr = $urandom;
      in_pc    = $urandom;
      in_stall = ($urandom_range(4, 0) == 0);
      in_flush = ($urandom_range(19, 0) == 0);
      rd_a     = 5'($urandom_range(7, 0));
      rd_b     = 5'($urandom_range(7, 0));
      if (i == 300) begin
        #3 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
